// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and instruction field layout for cpu_sequencer
package cpu_pkg;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_JZD  = 3'b011;
    localparam logic [2:0] OP_JZU  = 3'b100;
    localparam logic [2:0] OP_JD   = 3'b101;
    localparam logic [2:0] OP_JU   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_e;

    localparam int IR_OP_MSB   = 7;
    localparam int IR_OP_LSB   = 5;
    localparam int IR_RD_MSB   = 4;
    localparam int IR_RD_LSB   = 3;
    localparam int IR_RSVD_BIT = 2;
    localparam int IR_IMM_MSB  = 1;
    localparam int IR_IMM_LSB  = 0;

    function automatic logic op_writes_reg(input logic [2:0] op);
        return (op == OP_MOV) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/reg_file_4x2.sv
// rtl/reg_file_4x2.sv - four 2-bit registers, async read, sync write, async clear
module reg_file_4x2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raddr,
    output logic [1:0] rdata,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [1:0] wdata
);

    logic [3:0][1:0] regs_q;
    logic [3:0][1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[raddr];

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute controller owning PC, IR and register file
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_ack,
    output logic [1:0]      alu_a,
    output logic [1:0]      alu_b,
    output logic [2:0]      alu_sel,
    input  logic [1:0]      alu_out,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            req_q, req_d;
    logic [1:0]      alu_a_q, alu_a_d;
    logic [1:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_sel_q, alu_sel_d;

    logic [2:0]      op;
    logic [1:0]      rd;
    logic [1:0]      imm;
    logic [PC_W-1:0] imm_ext;
    logic            rf_we;
    logic [1:0]      rf_rdata;
    logic            unused_rsvd;

    assign op          = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign rd          = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign imm         = ir_q[IR_IMM_MSB:IR_IMM_LSB];
    assign imm_ext     = PC_W'(imm);
    assign unused_rsvd = ir_q[IR_RSVD_BIT];

    reg_file_4x2 u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (rd),
        .rdata (rf_rdata),
        .we    (rf_we),
        .waddr (rd),
        .wdata (alu_out)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        req_d     = req_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        rf_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
            end
            FETCH: begin
                // req_q guards against an ack racing the first FETCH cycle after reset
                if (imem_ack && req_q) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_a_d   = imm;
                alu_b_d   = rf_rdata;
                alu_sel_d = op;
                state_d   = EXEC;
            end
            EXEC: begin
                rf_we = op_writes_reg(op);
                // alu_b_q holds reg[rd] captured in DECODE, so it doubles as the zero test
                case (op)
                    OP_JZD:  pc_d = (alu_b_q == 2'b00) ? pc_q + imm_ext : pc_q + PC_ONE;
                    OP_JZU:  pc_d = (alu_b_q == 2'b00) ? pc_q - imm_ext : pc_q + PC_ONE;
                    OP_JD:   pc_d = pc_q + imm_ext;
                    OP_JU:   pc_d = pc_q - imm_ext;
                    OP_HALT: pc_d = pc_q;
                    default: pc_d = pc_q + PC_ONE;
                endcase
                if (op == OP_HALT) begin
                    state_d = HALT;
                end else if (run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
                req_d = (state_d == FETCH);
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            req_q     <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            req_q     <= req_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign retire    = (state_q == EXEC);
    assign halted    = (state_q == HALT);

endmodule
